instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the MIPS-lite main decoder: turns field-level requests (op, rs, rt, rd, imm) into 32-bit
//  MIPS-lite words and streams them into instruction memory through a write port, starting at BASE_ADDR.
//  Sits between the testbench/boot host and imem. Fills imem before the single-cycle core runs.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of the first written word; must be word-aligned
//  MAX_WORDS  256            capacity in words; stream ends automatically at this count
//  ADDR_W     32             width of imem_addr
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       1-cycle pulse: begin a load session (ignored unless IDLE or DONE)
//  finish     in   1       1-cycle pulse: no more requests; drain, then go to DONE
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept a request this cycle
//  req_op     in   4       op_sel_t: ADD,SUB,AND,OR,SLT,JMNOR,LW,SW,BEQ,ORI,BLTZAL (0..10)
//  req_rs     in   5       rs field
//  req_rt     in   5       rt field
//  req_rd     in   5       rd field; used by R-type ops only
//  req_imm    in   16      immediate/offset; used by I-type ops only
//  imem_we    out  1       write strobe (valid)
//  imem_ready in   1       imem accepts the write this cycle
//  imem_addr  out  ADDR_W  byte address of the word being written
//  imem_wdata out  32      encoded instruction
//  busy       out  1       state is LOADING or DRAIN
//  done       out  1       state is DONE
//  err        out  1       sticky: illegal req_op seen this session
//  word_count out  9       words written to imem this session
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0,
//   err=0, word_count=0. Both buffer slots are empty. Reset mid-session abandons the session at once.
//  FSM:
//   IDLE    --start--> LOADING. Clear word_count and err, set address = BASE_ADDR.
//   LOADING --finish, or MAX_WORDS requests accepted--> DRAIN.
//   DRAIN   --buffer empty--> DONE.
//   DONE    --start--> LOADING, same clear as IDLE.
//  Handshakes: request accepted when req_valid & req_ready. Write retires when imem_we & imem_ready.
//   imem_we, addr and wdata stay stable until the write retires.
//  req_ready = (state==LOADING) & buffer not full & accepted_count < MAX_WORDS.
//  Encoding happens on accept and is registered into a 2-entry FIFO. Latency accept->imem_we is 1 cycle
//   when the buffer is empty. With imem_ready held high, throughput is 1 word/cycle.
//  Encoding table:
//   R-type:  {6'd0, rs, rt, rd, 5'd0, funct}. funct: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25,
//            SLT 6'h2A, JMNOR 6'h26.
//   I-type:  {opcode, rs, rt, imm}. opcode: LW 6'h23, SW 6'h2B, BEQ 6'h04, ORI 6'h0D, BLTZAL 6'h22.
//  req_op > 10: the request is accepted but nothing is buffered or written, err is set, and the request
//   is not counted toward MAX_WORDS.
//  imem_addr = BASE_ADDR + 4*word_count (mod 2^ADDR_W). word_count increments on each retired write.
//  Same-cycle events:
//   - start and finish together: start wins.
//   - finish together with a valid request: the request is accepted, then DRAIN.
//   - Accept while the FIFO pops: occupancy is unchanged.
//   - start while LOADING or DRAIN: ignored.
// STRUCTURE
//  Package mips_lite_pkg holds:
//   - op_sel_t enum
//   - OPC_RTYPE/LW/SW/BEQ/ORI/BLTZAL constants (shared with the decoder)
//   - FUNCT_ADD/SUB/AND/OR/SLT/JMNOR constants
//   - state_t enum {IDLE, LOADING, DRAIN, DONE}
//  Sub-module: instr_word_encode (combinational op+fields -> {word, illegal}). FIFO and FSM stay in the top.
// TESTING
//  1 Reset, start, then one ADD rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0x0, wdata=0x00221820.
//  2 Stream LW r8,4(r9) and SW r8,8(r9) back-to-back, imem_ready=1 -> wdata 0x8D280004 then 0xAD280008
//    on consecutive cycles; addr 0x0 then 0x4; word_count=2.
//  3 ORI r5,r0,0x00FF and BLTZAL rs=4 imm=0xFFFE, with imem_ready=0 for 3 cycles
//    -> req_ready drops after 2 accepts; data holds stable; wdata 0x340500FF then 0x8880FFFE.
//  4 req_op=15 mid-stream -> err=1 sticky, no write, next legal word lands at the next address.
//  5 MAX_WORDS=4 with 5 requests offered -> 4 written, req_ready=0, DRAIN then done=1 and busy=0.
//  6 reset asserted during DRAIN with 2 buffered words -> next cycle imem_we=0, IDLE, word_count=0.
//    A later start resumes at BASE_ADDR.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: operation selector, opcode/funct values and
// the loader FSM state type.
package mips_lite_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_OR     = 4'd3,
      OP_SLT    = 4'd4,
      OP_JMNOR  = 4'd5,
      OP_LW     = 4'd6,
      OP_SW     = 4'd7,
      OP_BEQ    = 4'd8,
      OP_ORI    = 4'd9,
      OP_BLTZAL = 4'd10
   } op_sel_t;

   localparam logic [5:0] OPC_RTYPE  = 6'h00;
   localparam logic [5:0] OPC_LW     = 6'h23;
   localparam logic [5:0] OPC_SW     = 6'h2B;
   localparam logic [5:0] OPC_BEQ    = 6'h04;
   localparam logic [5:0] OPC_ORI    = 6'h0D;
   localparam logic [5:0] OPC_BLTZAL = 6'h22;

   localparam logic [5:0] FUNCT_ADD   = 6'h20;
   localparam logic [5:0] FUNCT_SUB   = 6'h22;
   localparam logic [5:0] FUNCT_AND   = 6'h24;
   localparam logic [5:0] FUNCT_OR    = 6'h25;
   localparam logic [5:0] FUNCT_SLT   = 6'h2A;
   localparam logic [5:0] FUNCT_JMNOR = 6'h26;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOADING = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/instr_word_encode.sv
// Combinational encoder: operation selector plus register/immediate fields
// into one 32-bit MIPS-lite word; flags selector values with no encoding.
module instr_word_encode
   import mips_lite_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   logic [5:0] funct;
   logic [5:0] opcode;
   logic       rtype;

   always_comb begin
      funct     = 6'h00;
      opcode    = OPC_RTYPE;
      rtype     = 1'b1;
      illegal_o = 1'b0;
      case (op_sel_t'(op_i))
         OP_ADD:    funct = FUNCT_ADD;
         OP_SUB:    funct = FUNCT_SUB;
         OP_AND:    funct = FUNCT_AND;
         OP_OR:     funct = FUNCT_OR;
         OP_SLT:    funct = FUNCT_SLT;
         OP_JMNOR:  funct = FUNCT_JMNOR;
         OP_LW:     begin rtype = 1'b0; opcode = OPC_LW;     end
         OP_SW:     begin rtype = 1'b0; opcode = OPC_SW;     end
         OP_BEQ:    begin rtype = 1'b0; opcode = OPC_BEQ;    end
         OP_ORI:    begin rtype = 1'b0; opcode = OPC_ORI;    end
         OP_BLTZAL: begin rtype = 1'b0; opcode = OPC_BLTZAL; end
         default:   illegal_o = 1'b1;
      endcase
      if (illegal_o) begin
         word_o = 32'h0;
      end else if (rtype) begin
         word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, funct};
      end else begin
         word_o = {opcode, rs_i, rt_i, imm_i};
      end
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field-level instruction requests and streams the words into imem
// through a 2-entry write buffer, one session per start pulse.
module instr_encoder_loader
   import mips_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [15:0]       req_imm,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [8:0]        word_count,
   output state_t            dbg_state
);

   localparam logic [8:0] MAX_CNT = 9'(MAX_WORDS);

   // Valid/ready: a request moves on a cycle where req_valid & req_ready;
   // a write retires on a cycle where imem_we & imem_ready, and imem_we,
   // imem_addr and imem_wdata hold until that cycle.
   state_t      state_q, state_d;
   logic [31:0] slot0_q, slot0_d;
   logic [31:0] slot1_q, slot1_d;
   logic [1:0]  count_q, count_d;
   logic [8:0]  word_count_q, word_count_d;
   logic [8:0]  acc_count_q, acc_count_d;
   logic        err_q, err_d;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept, push, pop;

   instr_word_encode u_encode (
      .op_i      (req_op),
      .rs_i      (req_rs),
      .rt_i      (req_rt),
      .rd_i      (req_rd),
      .imm_i     (req_imm),
      .word_o    (enc_word),
      .illegal_o (enc_illegal)
   );

   assign req_ready  = (state_q == LOADING) && (count_q != 2'd2) && (acc_count_q < MAX_CNT);
   assign imem_we    = (count_q != 2'd0);
   assign imem_wdata = slot0_q;
   assign imem_addr  = ADDR_W'(BASE_ADDR) + (ADDR_W'(word_count_q) << 2);
   assign busy       = (state_q == LOADING) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign err        = err_q;
   assign word_count = word_count_q;
   assign dbg_state  = state_q;

   assign accept = req_valid & req_ready;
   assign push   = accept & ~enc_illegal;
   assign pop    = imem_we & imem_ready;

   always_comb begin
      state_d      = state_q;
      slot0_d      = slot0_q;
      slot1_d      = slot1_q;
      count_d      = count_q;
      word_count_d = word_count_q;
      acc_count_d  = acc_count_q;
      err_d        = err_q;

      // Shift buffer: slot0 is always the head presented to imem.
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) slot0_d = enc_word;
            else                 slot1_d = enc_word;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               slot0_d = enc_word;
            end else begin
               slot0_d = slot1_q;
               slot1_d = enc_word;
            end
         end
         default: ;
      endcase

      if (pop)                  word_count_d = word_count_q + 9'd1;
      if (push)                 acc_count_d  = acc_count_q + 9'd1;
      if (accept & enc_illegal) err_d        = 1'b1;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = LOADING;
               word_count_d = 9'd0;
               acc_count_d  = 9'd0;
               err_d        = 1'b0;
            end
         end
         LOADING: if (finish || (acc_count_d >= MAX_CNT)) state_d = DRAIN;
         DRAIN:   if (count_q == 2'd0) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         slot0_q      <= 32'h0;
         slot1_q      <= 32'h0;
         count_q      <= 2'd0;
         word_count_q <= 9'd0;
         acc_count_q  <= 9'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot0_q      <= slot0_d;
         slot1_q      <= slot1_d;
         count_q      <= count_d;
         word_count_q <= word_count_d;
         acc_count_q  <= acc_count_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized sessions,
// all outputs compared against a transaction-level reference model.
module tb_instr_encoder_loader;
   import mips_lite_pkg::*;

   localparam int          MAX_W = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        finish = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [4:0]  req_rs = 5'd0;
   logic [4:0]  req_rt = 5'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [15:0] req_imm = 16'd0;
   logic        imem_we;
   logic        imem_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [8:0]  word_count;
   state_t      dbg_state;

   logic fixed_ready = 1'b1;
   logic rand_en = 1'b0;
   logic rand_bit = 1'b1;
   assign imem_ready = rand_en ? rand_bit : fixed_ready;

   int n_checks = 0;
   int n_pass = 0;

   instr_encoder_loader #(
      .BASE_ADDR (BASE),
      .MAX_WORDS (MAX_W),
      .ADDR_W    (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .finish     (finish),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rs     (req_rs),
      .req_rt     (req_rt),
      .req_rd     (req_rd),
      .req_imm    (req_imm),
      .imem_we    (imem_we),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rand_bit = ($urandom_range(0, 3) != 0);
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference encoding written from the instruction table with plain arithmetic.
   function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt,
                                           input int rd, input int imm);
      int funct, opc;
      funct = 0;
      opc   = 0;
      case (op)
         0: funct = 'h20;  1: funct = 'h22;  2: funct = 'h24;
         3: funct = 'h25;  4: funct = 'h2A;  5: funct = 'h26;
         6: opc = 'h23;    7: opc = 'h2B;    8: opc = 'h04;
         9: opc = 'h0D;    10: opc = 'h22;
         default: ;
      endcase
      if (op < 6) return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct);
      return 32'(opc * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm);
   endfunction

   // ---------------- reference model / scoreboard ----------------
   typedef enum {M_IDLE, M_LOAD, M_DRAIN, M_DONE} phase_t;
   phase_t      m_phase = M_IDLE;
   int          m_wc = 0;
   int          m_acc = 0;
   bit          m_err = 1'b0;
   bit          m_ok = 1'b0;
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      bit exp_ready, exp_we, acc, ret;
      int size_before;
      exp_ready = (m_phase == M_LOAD) && (exp_q.size() < 2) && (m_acc < MAX_W);
      exp_we    = (exp_q.size() != 0);
      if (m_ok) begin
         check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
         check_eq("imem_we", 32'(imem_we), 32'(exp_we));
         check_eq("busy", 32'(busy), 32'(m_phase == M_LOAD || m_phase == M_DRAIN));
         check_eq("done", 32'(done), 32'(m_phase == M_DONE));
         check_eq("err", 32'(err), 32'(m_err));
         check_eq("word_count", 32'(word_count), 32'(m_wc));
         if (exp_we) begin
            check_eq("wdata", imem_wdata, exp_q[0]);
            check_eq("addr", imem_addr, BASE + 32'(4 * m_wc));
         end
      end
      if (reset) begin
         m_phase = M_IDLE;
         m_wc    = 0;
         m_acc   = 0;
         m_err   = 1'b0;
         exp_q.delete();
         m_ok    = 1'b1;
      end else if (m_ok) begin
         size_before = exp_q.size();
         acc = req_valid && exp_ready;
         ret = exp_we && imem_ready;
         if (ret) begin
            void'(exp_q.pop_front());
            m_wc++;
         end
         if (acc) begin
            if (int'(req_op) > 10) m_err = 1'b1;
            else begin
               exp_q.push_back(ref_enc(int'(req_op), int'(req_rs), int'(req_rt),
                                       int'(req_rd), int'(req_imm)));
               m_acc++;
            end
         end
         case (m_phase)
            M_IDLE, M_DONE: if (start) begin
               m_phase = M_LOAD;
               m_wc    = 0;
               m_acc   = 0;
               m_err   = 1'b0;
            end
            M_LOAD:  if (finish || m_acc >= MAX_W) m_phase = M_DRAIN;
            M_DRAIN: if (size_before == 0) m_phase = M_DONE;
            default: ;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_finish();
      finish = 1'b1;
      tick();
      finish = 1'b0;
   endtask

   task automatic send_req(input int op, input int rs, input int rt, input int rd, input int imm);
      bit took;
      req_op    = 4'(op);
      req_rs    = 5'(rs);
      req_rt    = 5'(rt);
      req_rd    = 5'(rd);
      req_imm   = 16'(imm);
      req_valid = 1'b1;
      took      = 1'b0;
      for (int i = 0; i < 50 && !took; i++) begin
         took = req_ready;
         tick();
      end
      req_valid = 1'b0;
      if (!took) check_eq("req_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && !done; i++) tick();
      check_eq("done_wait", 32'(done), 32'd1);
   endtask

   task automatic wait_not_busy();
      for (int i = 0; i < 200 && busy; i++) tick();
      check_eq("settle_wait", 32'(busy), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tick();
      tick();
      reset = 1'b0;
      check_eq("rst_imem_we", 32'(imem_we), 32'd0);
      check_eq("rst_addr", imem_addr, BASE);
      check_eq("rst_wdata", imem_wdata, 32'h0);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

      // Single ADD: write appears the cycle after accept.
      pulse_start();
      send_req(0, 1, 2, 3, 0);
      check_eq("t1_we", 32'(imem_we), 32'd1);
      check_eq("t1_addr", imem_addr, 32'h0);
      check_eq("t1_wdata", imem_wdata, 32'h0022_1820);
      pulse_finish();
      wait_done();
      check_eq("t1_count", 32'(word_count), 32'd1);

      // LW then SW back-to-back at full rate.
      pulse_start();
      send_req(6, 9, 8, 0, 4);
      check_eq("t2_lw_wdata", imem_wdata, 32'h8D28_0004);
      check_eq("t2_lw_addr", imem_addr, 32'h0);
      send_req(7, 9, 8, 0, 8);
      check_eq("t2_sw_wdata", imem_wdata, 32'hAD28_0008);
      check_eq("t2_sw_addr", imem_addr, 32'h4);
      pulse_finish();
      wait_done();
      check_eq("t2_count", 32'(word_count), 32'd2);

      // Back-pressure: buffer fills after two accepts, head word holds.
      pulse_start();
      fixed_ready = 1'b0;
      send_req(9, 0, 5, 0, 'h00FF);
      send_req(10, 4, 0, 0, 'hFFFE);
      req_op = 4'd0; req_rs = 5'd1; req_rt = 5'd1; req_rd = 5'd1; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("t3_ready_low", 32'(req_ready), 32'd0);
         check_eq("t3_hold_wdata", imem_wdata, 32'h3405_00FF);
         tick();
      end
      req_valid = 1'b0;
      fixed_ready = 1'b1;
      tick();
      check_eq("t3_second_wdata", imem_wdata, 32'h8880_FFFE);
      send_req(0, 1, 1, 1, 0);
      pulse_finish();
      wait_done();
      check_eq("t3_count", 32'(word_count), 32'd3);

      // Illegal op mid-stream.
      pulse_start();
      send_req(0, 3, 4, 5, 0);
      send_req(15, 1, 1, 1, 0);
      check_eq("t4_err", 32'(err), 32'd1);
      send_req(3, 6, 7, 8, 0);
      pulse_finish();
      wait_done();
      check_eq("t4_err_sticky", 32'(err), 32'd1);
      check_eq("t4_count", 32'(word_count), 32'd2);

      // Capacity limit.
      pulse_start();
      for (int i = 0; i < MAX_W; i++) send_req(i, i + 1, i + 2, i + 3, 0);
      req_op = 4'd1; req_valid = 1'b1;
      check_eq("t5_ready_full", 32'(req_ready), 32'd0);
      tick();
      check_eq("t5_ready_full2", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      wait_done();
      check_eq("t5_busy", 32'(busy), 32'd0);
      check_eq("t5_count", 32'(word_count), 32'(MAX_W));

      // Reset while draining two buffered words.
      pulse_start();
      fixed_ready = 1'b0;
      send_req(0, 1, 2, 3, 0);
      send_req(1, 4, 5, 6, 0);
      pulse_finish();
      check_eq("t6_state_drain", 32'(dbg_state), 32'(DRAIN));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("t6_we", 32'(imem_we), 32'd0);
      check_eq("t6_count", 32'(word_count), 32'd0);
      check_eq("t6_state", 32'(dbg_state), 32'(IDLE));
      fixed_ready = 1'b1;
      pulse_start();
      send_req(2, 7, 8, 9, 0);
      check_eq("t6_restart_addr", imem_addr, BASE);
      pulse_finish();
      wait_done();

      // Randomized sessions with random imem back-pressure.
      rand_en = 1'b1;
      for (int s = 0; s < 8; s++) begin
         pulse_start();
         for (int c = 0; c < 60; c++) begin
            req_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                                    : 4'($urandom_range(0, 10));
            req_rs    = 5'($urandom_range(0, 31));
            req_rt    = 5'($urandom_range(0, 31));
            req_rd    = 5'($urandom_range(0, 31));
            req_imm   = 16'($urandom_range(0, 65535));
            req_valid = ($urandom_range(0, 3) != 0);
            finish    = ($urandom_range(0, 29) == 0);
            start     = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            tick();
         end
         req_valid = 1'b0;
         start     = 1'b0;
         reset     = 1'b0;
         pulse_finish();
         wait_not_busy();
      end
      rand_en = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
